// File: rtl/reset_sequencer.sv
// Lock-qualified reset sequencer: filters PLL lock, stretches reset, then releases
// N_CH reset outputs in ascending order; re-enters on lock loss or software request.
module reset_sequencer #(
    parameter int N_CH      = 4,
    parameter int LOCK_FILT = 8,
    parameter int HOLD      = 16,
    parameter int STAGGER   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pll_lock,
    input  logic            sw_rst_req,
    output logic            sw_rst_ack,
    input  logic            lock_lost_clr,
    output logic [N_CH-1:0] rst_out,
    output logic            rst_done,
    output logic            lock_lost
);

    localparam int MAXV = (LOCK_FILT > HOLD) ?
                          ((LOCK_FILT > STAGGER) ? LOCK_FILT : STAGGER) :
                          ((HOLD > STAGGER) ? HOLD : STAGGER);
    localparam int CW   = $clog2(MAXV + 1);
    localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CW-1:0]  LF_END   = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0]  HOLD_END = CW'(HOLD - 1);
    localparam logic [CW-1:0]  STG_END  = CW'(STAGGER - 1);
    localparam logic [CHW-1:0] LAST_CH  = CHW'(N_CH - 1);

    typedef enum logic [1:0] {
        ST_QUAL    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [CHW-1:0] ch;
    logic           lock_m;
    logic           lock_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_QUAL;
            cnt        <= '0;
            ch         <= '0;
            rst_out    <= '1;
            rst_done   <= 1'b0;
            sw_rst_ack <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            sw_rst_ack <= 1'b0;
            if (lock_lost_clr)
                lock_lost <= 1'b0;

            // Lock loss beats the software request; any re-entry asserts every channel together.
            if (state != ST_QUAL && !lock_s) begin
                state    <= ST_QUAL;
                cnt      <= '0;
                ch       <= '0;
                rst_out  <= '1;
                rst_done <= 1'b0;
                if (state == ST_RELEASE || state == ST_RUN)
                    lock_lost <= 1'b1;
            end else if (state != ST_QUAL && sw_rst_req) begin
                sw_rst_ack <= 1'b1;
                state      <= ST_HOLD;
                cnt        <= '0;
                ch         <= '0;
                rst_out    <= '1;
                rst_done   <= 1'b0;
            end else begin
                case (state)
                    ST_QUAL: begin
                        if (!lock_s) begin
                            cnt <= '0;
                        end else if (cnt == LF_END) begin
                            state <= ST_HOLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (cnt == HOLD_END) begin
                            cnt        <= '0;
                            rst_out[0] <= 1'b0;
                            if (N_CH == 1) begin
                                state    <= ST_RUN;
                                rst_done <= 1'b1;
                            end else begin
                                state <= ST_RELEASE;
                                ch    <= CHW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt == STG_END) begin
                            cnt         <= '0;
                            rst_out[ch] <= 1'b0;
                            ch          <= ch + CHW'(1);
                            if (ch == LAST_CH) begin
                                state    <= ST_RUN;
                                rst_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_RUN: begin
                    end
                    default: state <= ST_QUAL;
                endcase
            end
        end
    end

endmodule
